// File: rtl/mat_mult_seq_if.sv
// Operand/result bundle between a Jacobian block (master) and the
// sequential 6x6 matrix multiplier (slave).
interface mat_mult_seq_if #(
  parameter int N = 6,
  parameter int W = 36
);
  logic                         start;
  logic [N-1:0][N-1:0][W-1:0]   dataa;
  logic [N-1:0][N-1:0][W-1:0]   datab;
  logic [N-1:0][N-1:0][W-1:0]   result;
  logic                         busy;
  logic                         done;

  modport master (output start, dataa, datab, input result, busy, done);
  modport slave  (input start, dataa, datab, output result, busy, done);
endinterface

// File: rtl/mat_mult_seq.sv
// Sequential 6x6 fixed-point matrix multiplier: 36 MACs walk the 6
// outer-product steps, then the saturated result is registered.

module mat_mult_mac #(
  parameter int W    = 36,
  parameter int AW   = 75,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W-1:0] sat
);
  logic signed [AW-1:0]  acc;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  sh;

  assign prod = a * b;
  assign sh   = acc >>> FRAC;

  always_ff @(posedge clk) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= acc + {{(AW-2*W){prod[2*W-1]}}, prod};
  end

  // In range when every bit above the result sign matches the accumulator sign.
  always_comb begin
    if ((&sh[AW-1:W-1]) || !(|sh[AW-1:W-1])) sat = sh[W-1:0];
    else if (sh[AW-1])                       sat = {1'b1, {(W-1){1'b0}}};
    else                                     sat = {1'b0, {(W-1){1'b1}}};
  end
endmodule

module mat_mult_seq #(
  parameter int FRAC = 16,
  parameter int W    = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  mat_mult_seq_if.slave bus
);
  localparam int N  = 6;
  localparam int AW = 2*W + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  state_t                     state, nxt;
  logic [2:0]                 k;
  logic [N-1:0][N-1:0][W-1:0] a_q, b_q, sat_val;
  logic                       accept, add;

  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (en) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = ACCUM;
      ACCUM:   if (k == 3'd5) nxt = FINAL;
      FINAL:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = en && (state == IDLE) && bus.start;
    add      = en && (state == ACCUM);
    bus.busy = (state != IDLE);
  end

  // Operands are snapshotted so the master may change its inputs mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      k   <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      k   <= '0;
      a_q <= bus.dataa;
      b_q <= bus.datab;
    end else if (add) begin
      k   <= k + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.done   <= 1'b0;
    end else if (en) begin
      bus.done <= (state == FINAL);
      if (state == FINAL) bus.result <= sat_val;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      mat_mult_mac #(.W(W), .AW(AW), .FRAC(FRAC)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .add (add),
        .a   (a_q[r][k]),
        .b   (b_q[k][c]),
        .sat (sat_val[r][c])
      );
    end
  end
endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: vector table plus hand-written
// multi-cycle sequences, all checked against a plain-arithmetic model.
module tb_mat_mult_seq;
  typedef logic [5:0][5:0][35:0] mat_t;

  typedef struct {
    mat_t a;
    mat_t b;
    mat_t exp;
    int   exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  mat_mult_seq_if bus ();

  mat_mult_seq dut (.clk(clk), .rst(rst), .en(en), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic mat_t ref_mul(input mat_t a, input mat_t b);
    mat_t m;
    logic signed [127:0] s;
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    mx = 128'sh7_FFFF_FFFF;
    mn = -128'sh8_0000_0000;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        s = '0;
        for (int k = 0; k < 6; k++)
          s = s + 128'($signed(a[r][k])) * 128'($signed(b[k][c]));
        s = s >>> 16;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        m[r][c] = s[35:0];
      end
    return m;
  endfunction

  function automatic mat_t rand_mat(input int full);
    mat_t m;
    logic [63:0] t;
    int x;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        if (full != 0) begin
          t = {$urandom(), $urandom()};
          m[r][c] = t[35:0];
        end else begin
          x = int'($urandom_range(0, 2097151)) - 1048576;
          m[r][c] = 36'(x);
        end
      end
    return m;
  endfunction

  function automatic mat_t embed(input int h[4][4]);
    mat_t m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r+1][c+1] = 36'(h[r][c]) <<< 15;
    return m;
  endfunction

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_mat(input string nm, input mat_t got, input mat_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          if (got[r][c] !== exp[r][c]) begin
            $display("FAIL %s: result[%0d][%0d] got %h expected %h", nm, r, c, got[r][c], exp[r][c]);
            return;
          end
    end
  endtask

  // Starts one operation at the next edge and waits for done (bounded).
  task automatic run_op(input mat_t a, input mat_t b, output mat_t res,
                        output int lat, output logic pulse_ok, output logic busy_ok);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    en = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_ok = bus.busy;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    busy_ok = busy_ok && !bus.busy;
    res = bus.result;
    @(negedge clk);
    pulse_ok = !bus.done;
  endtask

  vec_t  vecs[8];
  string vnames[8];
  int    t1[4][4] = '{'{0,-2,0,6}, '{2,0,0,4}, '{0,0,2,-2}, '{0,0,0,2}};
  int    t2[4][4] = '{'{2,0,0,1}, '{0,1,0,2}, '{0,0,4,0}, '{0,0,0,2}};

  initial begin
    mat_t res, a1, b1, a2, b2, m;
    int   lat, nf;
    logic pulse_ok, busy_ok;
    int   exp_done[$];
    mat_t exp_res[$];
    int   got_done[$];
    mat_t got_res[$];

    // identity times integer-valued matrix returns that matrix
    m = '0;
    for (int i = 0; i < 6; i++) m[i][i] = 36'h0_0001_0000;
    vecs[0].a = m;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) vecs[0].b[r][c] = 36'(r*16 + c) << 16;
    vecs[0].exp = vecs[0].b;
    vnames[0] = "identity";

    vecs[1].a = embed(t1);
    vecs[1].b = embed(t2);
    vecs[1].exp = ref_mul(vecs[1].a, vecs[1].b);
    vnames[1] = "xform";

    vecs[2].a = '0; vecs[2].b = '0;
    vecs[2].a[0][0] = 36'h7_FFFF_FFFF; vecs[2].b[0][0] = 36'h7_FFFF_FFFF;
    vecs[2].exp = '0; vecs[2].exp[0][0] = 36'h7_FFFF_FFFF;
    vnames[2] = "sat_pos";

    vecs[3].a = '0; vecs[3].b = '0;
    vecs[3].a[0][0] = 36'h8_0000_0001; vecs[3].b[0][0] = 36'h7_FFFF_FFFF;
    vecs[3].exp = '0; vecs[3].exp[0][0] = 36'h8_0000_0000;
    vnames[3] = "sat_neg";

    vecs[4].a = '0; vecs[4].b = '0;
    vecs[4].a[0][0] = 36'hF_FFFF_FFFF; vecs[4].b[0][0] = 36'h0_0000_8000;
    vecs[4].exp = '0; vecs[4].exp[0][0] = 36'hF_FFFF_FFFF;
    vnames[4] = "floor";

    for (int i = 5; i < 8; i++) begin
      vecs[i].a = rand_mat(i == 7 ? 1 : 0);
      vecs[i].b = rand_mat(i == 7 ? 1 : 0);
      vecs[i].exp = ref_mul(vecs[i].a, vecs[i].b);
      vnames[i] = (i == 7) ? "rand_full" : "rand_small";
    end
    for (int i = 0; i < 8; i++) vecs[i].exp_lat = 7;

    // reset state
    bus.start = 1'b0; bus.dataa = '0; bus.datab = '0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_mat("reset_result", bus.result, '0);
    chk_bit("reset_busy", bus.busy, 1'b0);
    chk_bit("reset_done", bus.done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, lat, pulse_ok, busy_ok);
      chk_mat(vnames[i], res, vecs[i].exp);
      chk_int({vnames[i], "_latency"}, lat, vecs[i].exp_lat);
      chk_bit({vnames[i], "_pulse"}, pulse_ok, 1'b1);
      chk_bit({vnames[i], "_busy"}, busy_ok, 1'b1);
    end

    // start held high: requests while busy dropped; operand change mid-run ignored
    a1 = rand_mat(0); b1 = rand_mat(0);
    a2 = rand_mat(0); b2 = rand_mat(0);
    nf = 0;
    for (int cyc = 0; cyc < 40; cyc++)
      if (cyc < 16 && cyc >= nf) begin
        exp_done.push_back(cyc + 7);
        exp_res.push_back(cyc < 3 ? ref_mul(a1, b1) : ref_mul(a2, b2));
        nf = cyc + 8;
      end
    bus.dataa = a1; bus.datab = b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.start = (cyc < 16);
      if (cyc == 3) begin bus.dataa = a2; bus.datab = b2; end
      @(negedge clk);
      if (bus.done) begin got_done.push_back(cyc); got_res.push_back(bus.result); end
    end
    chk_int("hold_count", got_done.size(), exp_done.size());
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      chk_int("hold_done_cycle", got_done[i], exp_done[i]);
      chk_mat("hold_result", got_res[i], exp_res[i]);
    end

    // enable stall during ACCUM, then stretch done with en low
    a1 = rand_mat(0); b1 = rand_mat(0);
    bus.dataa = a1; bus.datab = b1;
    got_done.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.start = (cyc == 0);
      en = !(cyc inside {3, 4, 5, 11, 12});
      @(negedge clk);
      if (bus.done) got_done.push_back(cyc);
      if (cyc == 10) chk_mat("stall_result", bus.result, ref_mul(a1, b1));
    end
    en = 1'b1;
    chk_int("stall_done_len", got_done.size(), 3);
    if (got_done.size() > 0) chk_int("stall_done_first", got_done[0], 10);
    if (got_done.size() > 2) chk_int("stall_done_last", got_done[2], 12);

    // reset mid-operation, then restart two cycles later
    a1 = rand_mat(0); b1 = rand_mat(0);
    a2 = rand_mat(0); b2 = rand_mat(0);
    bus.dataa = a1; bus.datab = b1;
    got_done.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.start = (cyc == 0) || (cyc == 5);
      rst = (cyc == 3);
      if (cyc == 4) begin bus.dataa = a2; bus.datab = b2; end
      @(negedge clk);
      if (bus.done) got_done.push_back(cyc);
      if (cyc == 3) begin
        chk_mat("rst_mid_result", bus.result, '0);
        chk_bit("rst_mid_busy", bus.busy, 1'b0);
      end
      if (cyc == 12) chk_mat("rst_restart_result", bus.result, ref_mul(a2, b2));
    end
    rst = 1'b0;
    chk_int("rst_done_count", got_done.size(), 1);
    if (got_done.size() > 0) chk_int("rst_done_cycle", got_done[0], 12);

    // simultaneous rst and start
    bus.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    chk_bit("rst_start_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk_bit("rst_start_busy2", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
